// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Sequencing control for the five-stage pipeline. It resolves load-use
// stalls, CPSR-flag stalls, taken-branch redirects with instruction-memory
// refill, and data-memory wait states.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
`timescale 1ns/1ps

module pipeline_hazard_controller #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] id_rn,
    input  logic [3:0] id_rm,
    input  logic       id_uses_rn,
    input  logic       id_uses_rm,
    input  logic [3:0] id_cond,
    input  logic       ex_is_load,
    input  logic [3:0] ex_rd,
    input  logic       ex_sets_flags,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       pipe_hold,
    output logic       mem_timeout,
    output logic [1:0] ctrl_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        BR_REFILL = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic [7:0] wait_inc;
    logic       load_use;
    logic       flag_haz;

    assign load_use = ex_is_load &
                      ((id_uses_rn & (id_rn == ex_rd)) |
                       (id_uses_rm & (id_rm == ex_rd)));
    assign flag_haz = ex_sets_flags & (id_cond != 4'hE);
    assign wait_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
    assign ctrl_state = state_q;

    // Control outputs and next state; MEM_WAIT with memory ready resolves
    // exactly like RUN, so both share the RUN priority chain.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        state_d     = state_q;
        if (!reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
        end else if (mem_busy) begin
            pipe_hold = 1'b1;
            state_d   = (state_q == BR_REFILL) ? BR_REFILL : MEM_WAIT;
        end else if (state_q == BR_REFILL) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = BR_REFILL;
        end else if (load_use | flag_haz) begin
            idex_bubble = 1'b1;
            state_d     = RUN;
        end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            state_d = RUN;
        end
    end

    // State, consecutive-busy counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= mem_busy ? wait_inc : '0;
            if (mem_busy && (wait_inc >= LIMIT))
                mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic br_accept;
    assign br_accept = !mem_busy && (state_q != BR_REFILL) && ex_branch_taken;

    // Saturating stall-cycle and branch-flush event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (br_accept && (flush_events != 16'hFFFF))
                flush_events <= flush_events + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller (default build).
`timescale 1ns/1ps

module tb_pipeline_hazard_controller;

    logic       clk;
    logic       reset;
    logic [3:0] id_rn, id_rm, id_cond, ex_rd;
    logic       id_uses_rn, id_uses_rm, ex_is_load, ex_sets_flags;
    logic       ex_branch_taken, mem_busy;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
    logic [1:0] ctrl_state;

    int checks = 0;
    int errors = 0;

    // Reference model: pending refill, waiting-on-memory, busy run length.
    bit m_pending;
    bit m_in_wait;
    bit m_timeout;
    int m_busy_run;

    pipeline_hazard_controller #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_cond(id_cond), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_sets_flags(ex_sets_flags), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
        .mem_timeout(mem_timeout), .ctrl_state(ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending  = 0;
        m_in_wait  = 0;
        m_timeout  = 0;
        m_busy_run = 0;
    endtask

    // Advance the model by one rising edge with the inputs currently applied.
    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else if (mem_busy) begin
            if (m_busy_run < 255) m_busy_run++;
            if (m_busy_run >= 15) m_timeout = 1;
            m_in_wait = !m_pending;
        end else begin
            m_busy_run = 0;
            m_in_wait  = 0;
            m_pending  = !m_pending && ex_branch_taken;
        end
    endtask

    // Compare every DUT output with what the rules demand right now.
    task automatic compare_all();
        int e_pc, e_en, e_fl, e_bub, e_hold, e_ctrl, e_to;
        bit hazard;
        hazard = (ex_is_load && ((id_uses_rn && id_rn == ex_rd) ||
                                 (id_uses_rm && id_rm == ex_rd))) ||
                 (ex_sets_flags && id_cond != 4'hE);
        e_pc = 0; e_en = 0; e_fl = 0; e_bub = 0; e_hold = 0;
        e_ctrl = m_pending ? 1 : (m_in_wait ? 2 : 0);
        e_to = m_timeout ? 1 : 0;
        if (!reset) begin
            e_fl = 1; e_bub = 1; e_ctrl = 0; e_to = 0;
        end else if (mem_busy) begin
            e_hold = 1;
        end else if (m_pending) begin
            e_pc = 1; e_en = 1; e_fl = 1;
        end else if (ex_branch_taken) begin
            e_pc = 1; e_fl = 1; e_bub = 1;
        end else if (hazard) begin
            e_bub = 1;
        end else begin
            e_pc = 1; e_en = 1;
        end
        chk("pc_en", pc_en, e_pc);
        // ifid_en is a don't-care while a flush is loading the register
        if (!e_fl || !reset) chk("ifid_en", ifid_en, e_en);
        chk("ifid_flush", ifid_flush, e_fl);
        chk("idex_bubble", idex_bubble, e_bub);
        chk("pipe_hold", pipe_hold, e_hold);
        chk("ctrl_state", ctrl_state, e_ctrl);
        chk("mem_timeout", mem_timeout, e_to);
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        id_rn = 4'd0; id_rm = 4'd0; id_uses_rn = 0; id_uses_rm = 0;
        id_cond = 4'hE; ex_is_load = 0; ex_rd = 4'd0; ex_sets_flags = 0;
        ex_branch_taken = 0; mem_busy = 0;
    endtask

    initial begin
        bit busy_state;
        busy_state = 0;
        quiet();
        reset = 1'b0;
        model_reset();

        // Reset values
        settle();
        chk("rst_pc_en", pc_en, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_bubble", idex_bubble, 1);
        chk("rst_ctrl_state", ctrl_state, 0);
        advance();
        reset = 1'b1;
        settle();
        chk("run_pc_en", pc_en, 1);
        advance();

        // Load-use: LDR r3 in EX, IF/ID reads r3 through rn
        ex_is_load = 1; ex_rd = 4'd3; id_uses_rn = 1; id_rn = 4'd3;
        settle();
        chk("lu_pc_en", pc_en, 0);
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_bubble", idex_bubble, 1);
        advance();
        quiet();
        settle();
        chk("lu_after_pc_en", pc_en, 1);
        advance();

        // Flag hazard: conditional EQ stalls, always-execute does not
        ex_sets_flags = 1; id_cond = 4'h0;
        settle();
        chk("flag_eq_pc_en", pc_en, 0);
        advance();
        id_cond = 4'hE;
        settle();
        chk("flag_al_pc_en", pc_en, 1);
        chk("flag_al_bubble", idex_bubble, 0);
        advance();
        quiet();

        // Branch: redirect, refill (branch input ignored), back to RUN
        ex_branch_taken = 1;
        settle();
        chk("br_n_flush", ifid_flush, 1);
        chk("br_n_bubble", idex_bubble, 1);
        chk("br_n_pc_en", pc_en, 1);
        advance();
        settle();
        chk("br_n1_state", ctrl_state, 1);
        chk("br_n1_flush", ifid_flush, 1);
        chk("br_n1_bubble", idex_bubble, 0);
        advance();
        ex_branch_taken = 0;
        settle();
        chk("br_n2_state", ctrl_state, 0);
        chk("br_n2_flush", ifid_flush, 0);
        advance();

        // 20 busy cycles: timeout after the 15th, sticky afterwards
        mem_busy = 1;
        for (int i = 0; i < 20; i++) begin
            settle();
            chk("busy_hold", pipe_hold, 1);
            chk("busy_timeout", mem_timeout, (i >= 15) ? 1 : 0);
            advance();
        end
        mem_busy = 0;
        settle();
        chk("busy_end_state", ctrl_state, 2);
        chk("busy_end_pc_en", pc_en, 1);
        chk("busy_end_timeout", mem_timeout, 1);
        advance();

        // mem_busy for 3 cycles during BR_REFILL
        ex_branch_taken = 1;
        settle();
        advance();
        ex_branch_taken = 0;
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("refill_busy_state", ctrl_state, 1);
            chk("refill_busy_flush", ifid_flush, 0);
            advance();
        end
        mem_busy = 0;
        settle();
        chk("refill_done_flush", ifid_flush, 1);
        chk("refill_done_state", ctrl_state, 1);
        advance();
        settle();
        chk("refill_run_state", ctrl_state, 0);
        chk("refill_run_flush", ifid_flush, 0);
        advance();

        // Reset asserted mid-refill takes effect without a clock edge
        ex_branch_taken = 1;
        settle();
        advance();
        ex_branch_taken = 0;
        settle();
        chk("pre_rst_state", ctrl_state, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_state", ctrl_state, 0);
        chk("async_rst_flush", ifid_flush, 1);
        chk("async_rst_pc_en", pc_en, 0);
        chk("async_rst_timeout", mem_timeout, 0);
        compare_all();
        advance();
        reset = 1'b1;
        settle();
        chk("post_rst_state", ctrl_state, 0);
        advance();

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            ex_rd         = 4'($urandom_range(0, 3));
            id_rn         = 4'($urandom_range(0, 3));
            id_rm         = 4'($urandom_range(0, 3));
            id_uses_rn    = 1'($urandom_range(0, 1));
            id_uses_rm    = 1'($urandom_range(0, 1));
            id_cond       = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
            ex_is_load    = ($urandom_range(0, 9) < 3);
            ex_sets_flags = ($urandom_range(0, 9) < 3);
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            if (busy_state) busy_state = ($urandom_range(0, 99) < 85);
            else            busy_state = ($urandom_range(0, 99) < 10);
            mem_busy = busy_state;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
            end
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
